// File: rtl/scan_timing_gen.sv
// Raster timing generator: free-running horizontal/vertical scan counters
// with sync pulses, active-video flag, raw pixel coordinates and
// line/frame terminal strobes. All outputs are registered and decoded from
// the next-state counter values, so they never lag the coordinates.
module scan_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int X_W      = 10,
   parameter int Y_W      = 10
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           en_i,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
   output logic           active_o,
   output logic           hsync_o,
   output logic           vsync_o,
   output logic           line_end_o,
   output logic           frame_end_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Boundaries held at counter width so every compare is full width.
   localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] HS_START   = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] HS_END     = X_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] VS_START   = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] VS_END     = Y_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
   localparam logic [X_W-1:0] X_ONE      = X_W'(1);
   localparam logic [Y_W-1:0] Y_ONE      = Y_W'(1);

   logic [X_W-1:0] h;
   logic [Y_W-1:0] v;
   logic [X_W-1:0] h_nxt;
   logic [Y_W-1:0] v_nxt;
   logic           active_nxt;
   logic           hsync_nxt;
   logic           vsync_nxt;
   logic           line_end_nxt;
   logic           frame_end_nxt;

   // Next scan position and the output decode for that position.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      h_nxt = h + X_ONE;
      v_nxt = v;
      if (h == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v == V_LAST) ? '0 : v + Y_ONE;
      end
      active_nxt    = (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
      hsync_nxt     = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? HS_POL : ~HS_POL;
      vsync_nxt     = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
      line_end_nxt  = (h_nxt == H_LAST);
      frame_end_nxt = (h_nxt == H_LAST) && (v_nxt == V_LAST);
   end

   // Counter and output registers; reset wins, en_i=0 freezes everything.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      if (!rst_n_i) begin
         h           <= '0;
         v           <= '0;
         active_o    <= 1'b1;
         hsync_o     <= ~HS_POL;
         vsync_o     <= ~VS_POL;
         line_end_o  <= 1'b0;
         frame_end_o <= 1'b0;
      end else if (en_i) begin
         h           <= h_nxt;
         v           <= v_nxt;
         active_o    <= active_nxt;
         hsync_o     <= hsync_nxt;
         vsync_o     <= vsync_nxt;
         line_end_o  <= line_end_nxt;
         frame_end_o <= frame_end_nxt;
      end
   end

   assign x_o = h;
   assign y_o = v;

endmodule
